// File: rtl/lut_sweep_capture_pkg.sv
// Shared types and sizing helpers for the LUT truth-table sweep/capture block.
package lut_sweep_capture_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SWEEP   = 2'd1,
    ST_FLUSH   = 2'd2,
    ST_PUBLISH = 2'd3
  } sweep_state_t;

  localparam int DEF_LUT_IN = 6;
  localparam int DEF_LAT    = 1;

  // Sweep depth for a given LUT address width.
  function automatic int depth_of(input int lut_in);
    return 1 << lut_in;
  endfunction

  // Width of a counter that must reach n-1 (at least one bit).
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/lut_sweep_addr_gen.sv
// Sweep address counter plus a LAT-deep delay line that tells the capture logic
// which table bit the current LUT response belongs to.
module lut_sweep_addr_gen
  import lut_sweep_capture_pkg::*;
#(
  parameter int LUT_IN = DEF_LUT_IN,
  parameter int LAT    = DEF_LAT
) (
  input  logic              clk_buf,
  input  logic              rst,
  input  logic              step,
  input  logic              hold,
  output logic [LUT_IN-1:0] addr,
  output logic              last,
  output logic              wr_en,
  output logic [LUT_IN-1:0] wr_idx
);

  localparam logic [LUT_IN-1:0] ADDR_MAX = '1;

  logic [LUT_IN-1:0] addr_reg, addr_next;

  // Counts up while sweeping, parks on the last address while flushing, else sits at 0.
  always_comb begin
    addr_next = '0;
    if (step) begin
      addr_next = (addr_reg == ADDR_MAX) ? addr_reg : addr_reg + LUT_IN'(1);
    end else if (hold) begin
      addr_next = addr_reg;
    end
  end

  always_ff @(posedge clk_buf or posedge rst) begin
    if (rst) addr_reg <= '0;
    else     addr_reg <= addr_next;
  end

  assign addr = addr_reg;
  assign last = (addr_reg == ADDR_MAX);

  generate
    if (LAT == 0) begin : g_direct
      assign wr_en  = step;
      assign wr_idx = addr_reg;
    end else begin : g_delay
      logic              vld_reg [LAT];
      logic [LUT_IN-1:0] idx_reg [LAT];
      for (genvar gi = 0; gi < LAT; gi++) begin : g_stage
        if (gi == 0) begin : g_head
          always_ff @(posedge clk_buf or posedge rst) begin
            if (rst) begin
              vld_reg[0] <= 1'b0;
              idx_reg[0] <= '0;
            end else begin
              vld_reg[0] <= step;
              idx_reg[0] <= addr_reg;
            end
          end
        end else begin : g_tail
          always_ff @(posedge clk_buf or posedge rst) begin
            if (rst) begin
              vld_reg[gi] <= 1'b0;
              idx_reg[gi] <= '0;
            end else begin
              vld_reg[gi] <= vld_reg[gi-1];
              idx_reg[gi] <= idx_reg[gi-1];
            end
          end
        end
      end
      assign wr_en  = vld_reg[LAT-1];
      assign wr_idx = idx_reg[LAT-1];
    end
  endgenerate

endmodule

// File: rtl/lut_sweep_capture.sv
// Sweeps every address of one or more LUTs, captures their responses into truth
// tables and publishes them with a per-channel changed flag.
module lut_sweep_capture
  import lut_sweep_capture_pkg::*;
#(
  parameter int   LUT_IN = DEF_LUT_IN,
  parameter int   NUM_CH = 1,
  parameter int   LAT    = DEF_LAT,
  localparam int  DEPTH  = depth_of(LUT_IN)
) (
  input  logic                    clk_buf,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    cont_mode,
  output logic [LUT_IN-1:0]       lut_din,
  input  logic [NUM_CH-1:0]       lut_dout,
  output logic [NUM_CH*DEPTH-1:0] snap_data,
  output logic                    snap_valid,
  output logic [NUM_CH-1:0]       changed,
  output logic                    busy
);

  localparam int                FLUSH_W    = cnt_width(LAT);
  localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'((LAT == 0) ? 0 : LAT - 1);

  sweep_state_t       state_reg, state_next;
  logic [FLUSH_W-1:0] flush_cnt_reg, flush_cnt_next;
  logic [DEPTH-1:0]   capture_reg [NUM_CH];
  logic [DEPTH-1:0]   snap_reg    [NUM_CH];
  logic [NUM_CH-1:0]  changed_reg, diff;
  logic               valid_reg, first_reg;
  logic               last, wr_en;
  logic [LUT_IN-1:0]  wr_idx;

  lut_sweep_addr_gen #(
    .LUT_IN (LUT_IN),
    .LAT    (LAT)
  ) u_addr_gen (
    .clk_buf (clk_buf),
    .rst     (rst),
    .step    (state_reg == ST_SWEEP),
    .hold    (state_reg == ST_FLUSH),
    .addr    (lut_din),
    .last    (last),
    .wr_en   (wr_en),
    .wr_idx  (wr_idx)
  );

  always_comb begin
    state_next     = state_reg;
    flush_cnt_next = '0;
    case (state_reg)
      ST_IDLE:    if (start) state_next = ST_SWEEP;
      ST_SWEEP:   if (last) state_next = (LAT == 0) ? ST_PUBLISH : ST_FLUSH;
      ST_FLUSH: begin
        flush_cnt_next = flush_cnt_reg + FLUSH_W'(1);
        if (flush_cnt_reg == FLUSH_LAST) state_next = ST_PUBLISH;
      end
      ST_PUBLISH: state_next = cont_mode ? ST_SWEEP : ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_buf or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      flush_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      flush_cnt_reg <= flush_cnt_next;
    end
  end

  // Responses land by index, so table order never depends on sweep timing.
  always_ff @(posedge clk_buf or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) capture_reg[c] <= '0;
    end else if (wr_en) begin
      for (int c = 0; c < NUM_CH; c++) capture_reg[c][wr_idx] <= lut_dout[c];
    end
  end

  always_ff @(posedge clk_buf or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) snap_reg[c] <= '0;
      changed_reg <= '0;
      valid_reg   <= 1'b0;
      first_reg   <= 1'b1;
    end else begin
      valid_reg <= (state_reg == ST_PUBLISH);
      if (state_reg == ST_PUBLISH) begin
        for (int c = 0; c < NUM_CH; c++) snap_reg[c] <= capture_reg[c];
        changed_reg <= first_reg ? '0 : diff;
        first_reg   <= 1'b0;
      end
    end
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    assign diff[gi]                      = |(capture_reg[gi] ^ snap_reg[gi]);
    assign snap_data[gi*DEPTH +: DEPTH] = snap_reg[gi];
  end

  assign snap_valid = valid_reg;
  assign changed    = changed_reg;
  assign busy       = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_lut_sweep_capture.sv
// Directed bench: a 6-input parity LUT behind a registered output (LAT=1), and a
// two-channel combinational LUT (LAT=0) for the multi-channel table layout.
module tb_lut_sweep_capture;

  logic         clk_buf = 1'b0;
  logic         rst;
  logic         start_a, cont_a, use_xnor;
  logic [5:0]   lut_din_a;
  logic [0:0]   lut_dout_a;
  logic [63:0]  snap_data_a;
  logic         snap_valid_a, busy_a;
  logic [0:0]   changed_a;
  logic         start_b, cont_b;
  logic [5:0]   lut_din_b;
  logic [1:0]   lut_dout_b;
  logic [127:0] snap_data_b;
  logic         snap_valid_b, busy_b;
  logic [1:0]   changed_b;

  int checks   = 0;
  int failures = 0;

  localparam logic [127:0] XOR_TAB  = 128'h6996966996696996;
  localparam logic [127:0] XNOR_TAB = 128'h9669699669969669;

  always #5 clk_buf = ~clk_buf;

  lut_sweep_capture #(.LUT_IN(6), .NUM_CH(1), .LAT(1)) dut_a (
    .clk_buf(clk_buf), .rst(rst), .start(start_a), .cont_mode(cont_a),
    .lut_din(lut_din_a), .lut_dout(lut_dout_a), .snap_data(snap_data_a),
    .snap_valid(snap_valid_a), .changed(changed_a), .busy(busy_a)
  );

  lut_sweep_capture #(.LUT_IN(6), .NUM_CH(2), .LAT(0)) dut_b (
    .clk_buf(clk_buf), .rst(rst), .start(start_b), .cont_mode(cont_b),
    .lut_din(lut_din_b), .lut_dout(lut_dout_b), .snap_data(snap_data_b),
    .snap_valid(snap_valid_b), .changed(changed_b), .busy(busy_b)
  );

  // Registered parity LUT (one cycle of latency); use_xnor inverts it.
  always @(posedge clk_buf) lut_dout_a <= {(^lut_din_a) ^ use_xnor};
  assign lut_dout_b = {1'b1, lut_din_b[0]};

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk_buf);
    #1;
  endtask

  task automatic pulse_start_a();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
  endtask

  // Edges from the current point until snap_valid_a is seen (300 = timed out).
  task automatic wait_valid_a(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!snap_valid_a && n < 300);
  endtask

  initial begin
    int n, k, pulses, busy_gap, lat, extra;
    bit restarted;
    rst = 1'b1; start_a = 1'b0; cont_a = 1'b0; use_xnor = 1'b0;
    start_b = 1'b0; cont_b = 1'b0;
    repeat (3) @(posedge clk_buf);
    #1 rst = 1'b0;
    tick();
    chk("rst_lut_din", 128'(lut_din_a), 128'(0));
    chk("rst_busy", 128'(busy_a), 128'(0));
    chk("rst_snap_valid", 128'(snap_valid_a), 128'(0));
    chk("rst_snap_data", 128'(snap_data_a), 128'(0));
    chk("rst_changed", 128'(changed_a), 128'(0));

    // Single XOR sweep
    pulse_start_a();
    chk("start_busy", 128'(busy_a), 128'(1));
    wait_valid_a(n);
    chk("xor_latency", 128'(n), 128'(66));
    chk("xor_table", 128'(snap_data_a), XOR_TAB);
    chk("xor_changed_first", 128'(changed_a), 128'(0));
    tick();
    chk("xor_valid_pulse", 128'(snap_valid_a), 128'(0));
    chk("xor_idle_busy", 128'(busy_a), 128'(0));
    chk("xor_table_hold", 128'(snap_data_a), XOR_TAB);

    // start re-pulsed at address 20 must be ignored
    pulse_start_a();
    pulses = 0; busy_gap = 0; lat = 0; restarted = 1'b0;
    for (int i = 1; i <= 150; i++) begin
      if (lut_din_a == 6'd20 && !restarted) begin
        start_a = 1'b1;
        restarted = 1'b1;
      end else begin
        start_a = 1'b0;
      end
      tick();
      if (snap_valid_a) begin
        pulses++;
        if (lat == 0) lat = i;
      end
      if (!busy_a && pulses == 0) busy_gap++;
    end
    start_a = 1'b0;
    chk("restart_pulses", 128'(pulses), 128'(1));
    chk("restart_latency", 128'(lat), 128'(66));
    chk("restart_busy_gap", 128'(busy_gap), 128'(0));
    chk("restart_changed", 128'(changed_a), 128'(0));

    // Continuous mode, model swapped to XNOR after the first publish
    cont_a = 1'b1;
    pulse_start_a();
    wait_valid_a(n);
    chk("cont1_latency", 128'(n), 128'(66));
    chk("cont1_changed", 128'(changed_a), 128'(0));
    use_xnor = 1'b1;
    wait_valid_a(n);
    chk("cont2_period", 128'(n), 128'(66));
    chk("cont2_table", 128'(snap_data_a), XNOR_TAB);
    chk("cont2_changed", 128'(changed_a), 128'(1));
    wait_valid_a(n);
    chk("cont3_period", 128'(n), 128'(66));
    chk("cont3_changed", 128'(changed_a), 128'(0));

    // cont_mode dropped at address 10: finish, publish, then idle
    k = 0;
    while (lut_din_a != 6'd10 && k < 100) begin
      tick();
      k++;
    end
    chk("reach_addr10", 128'(k < 100), 128'(1));
    cont_a = 1'b0;
    wait_valid_a(n);
    chk("drop_remaining", 128'(n), 128'(56));
    chk("drop_busy", 128'(busy_a), 128'(0));
    chk("drop_lut_din", 128'(lut_din_a), 128'(0));
    extra = 0;
    repeat (80) begin
      tick();
      if (snap_valid_a || busy_a) extra++;
    end
    chk("drop_stays_idle", 128'(extra), 128'(0));

    // Reset at address 30 aborts the sweep
    pulse_start_a();
    k = 0;
    while (lut_din_a != 6'd30 && k < 100) begin
      tick();
      k++;
    end
    chk("reach_addr30", 128'(k < 100), 128'(1));
    rst = 1'b1;
    #1;
    chk("abort_lut_din", 128'(lut_din_a), 128'(0));
    chk("abort_busy", 128'(busy_a), 128'(0));
    chk("abort_snap_data", 128'(snap_data_a), 128'(0));
    chk("abort_snap_valid", 128'(snap_valid_a), 128'(0));
    tick();
    tick();
    rst = 1'b0;
    extra = 0;
    repeat (80) begin
      tick();
      if (snap_valid_a) extra++;
    end
    chk("abort_no_publish", 128'(extra), 128'(0));
    pulse_start_a();
    wait_valid_a(n);
    chk("after_rst_latency", 128'(n), 128'(66));
    chk("after_rst_table", 128'(snap_data_a), XNOR_TAB);
    chk("after_rst_changed", 128'(changed_a), 128'(0));

    // Two channels, combinational LUT
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
    end while (!snap_valid_b && n < 300);
    chk("b_latency", 128'(n), 128'(65));
    chk("b_ch0_table", 128'(snap_data_b[63:0]), 128'(64'hAAAAAAAAAAAAAAAA));
    chk("b_ch1_table", 128'(snap_data_b[127:64]), 128'(64'hFFFFFFFFFFFFFFFF));
    chk("b_changed", 128'(changed_b), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
